// File: rtl/tkm_pkg.sv
// Shared types and constants for the shared bit-serial adder scheduler.
package tkm_pkg;

  // Sequencer states: waiting for a request, shifting the add, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester identifiers as they appear on done_id and in the pointer.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // One-hot grant encodings, bit0 = A, bit1 = B.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  // Map a requester ID to its one-hot grant.
  function automatic logic [1:0] id_to_gnt(input logic id);
    return (id == ID_B) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/tkm_serial_add_dp.sv
// Bit-serial adder datapath: operand shift registers, carry flop,
// full-adder cell and result shift register. The add runs LSB-first;
// each shift consumes bit 0 of both operands and pushes the sum bit
// into the result MSB, so after WIDTH shifts the result is aligned.
module tkm_serial_add_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] res_nxt,
  output logic             carry_nxt
);

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic             s_bit;

  // Full-adder cell on the current LSBs and the running carry.
  always_comb begin
    s_bit     = x_q[0] ^ y_q[0] ^ c_q;
    carry_nxt = (x_q[0] & y_q[0]) | (x_q[0] & c_q) | (y_q[0] & c_q);
    res_nxt   = {s_bit, res_q[WIDTH-1:1]};
  end

  // Load operands at grant, then shift one bit per cycle while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
    end else if (load) begin
      x_q   <= op0;
      y_q   <= op1;
      res_q <= '0;
      c_q   <= 1'b0;
    end else if (shift) begin
      x_q   <= x_q >> 1;
      y_q   <= y_q >> 1;
      res_q <= res_nxt;
      c_q   <= carry_nxt;
    end
  end

endmodule

// File: rtl/tkm_add_sched.sv
// Round-robin scheduler that shares one bit-serial adder between
// requesters A and B. Handshake: a requester holds req high; the block
// samples requests only in IDLE, answers with a one-hot gnt held until
// the end of the done cycle, and signals a valid result with a single
// done pulse. Requests still high afterwards are re-arbitrated, with
// the pointer alternating so neither side starves.
module tkm_add_sched
  import tkm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a_op0,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] b_op0,
  input  logic [WIDTH-1:0] b_op1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state_q;
  state_t          state_nxt;
  logic [CW-1:0]   count_q;
  logic            ptr_q;
  logic            cur_id_q;
  logic            win_id;
  logic            load;
  logic            shift;
  logic            last;
  logic [WIDTH-1:0] sel_op0;
  logic [WIDTH-1:0] sel_op1;
  logic [WIDTH-1:0] res_nxt;
  logic            carry_nxt;

  // Arbitration: a lone requester wins; on a tie the pointer decides.
  always_comb begin
    win_id = ID_A;
    if (req_a && req_b) win_id = ptr_q;
    else if (req_b)     win_id = ID_B;
    sel_op0 = (win_id == ID_B) ? b_op0 : a_op0;
    sel_op1 = (win_id == ID_B) ? b_op1 : a_op1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and datapath controls.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (count_q == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= GNT_NONE;
      ptr_q    <= ID_A;
      cur_id_q <= ID_A;
      count_q  <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      done_id  <= ID_A;
    end else begin
      if (load) begin
        gnt      <= id_to_gnt(win_id);
        cur_id_q <= win_id;
        ptr_q    <= ~win_id;
        count_q  <= '0;
      end
      if (shift) count_q <= count_q + CW'(1);
      if (last) begin
        sum     <= res_nxt;
        cout    <= carry_nxt;
        done_id <= cur_id_q;
      end
      if (state_q == DONE) gnt <= GNT_NONE;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  tkm_serial_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .op0       (sel_op0),
    .op1       (sel_op1),
    .res_nxt   (res_nxt),
    .carry_nxt (carry_nxt)
  );

endmodule

// File: tb/tb_tkm_add_sched.sv
// Bench for tkm_add_sched: transaction-level reference model plus
// directed scenarios with hand-computed results.
module tb_tkm_add_sched;
  import tkm_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] a_op0 = '0, a_op1 = '0, b_op0 = '0, b_op1 = '0;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;
  state_t       state_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  tkm_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .a_op0(a_op0), .a_op1(a_op1), .b_op0(b_op0), .b_op1(b_op1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout), .state_dbg(state_dbg)
  );

  // reference model: operation timeline counted from the grant, result
  // from plain integer addition of the operands captured at grant
  int           age = 0;
  logic [1:0]   m_gnt = 2'b00;
  logic         m_busy = 0, m_done = 0, m_id = 0, m_cout = 0, m_ptr = 0;
  logic [W-1:0] m_sum = '0;
  logic [W:0]   pend = '0;
  logic         pend_id = 0;

  always @(posedge clk) begin
    if (rst) begin
      age = 0; m_gnt = 2'b00; m_busy = 0; m_done = 0; m_id = 0;
      m_cout = 0; m_sum = '0; m_ptr = 0;
    end else if (age == 0) begin
      if (req_a || req_b) begin
        pend_id = (req_a && req_b) ? m_ptr : req_b;
        m_ptr   = !pend_id;
        pend    = pend_id ? ({1'b0, b_op0} + {1'b0, b_op1})
                          : ({1'b0, a_op0} + {1'b0, a_op1});
        m_gnt   = pend_id ? 2'b10 : 2'b01;
        m_busy  = 1;
        age     = 1;
      end
    end else begin
      age = age + 1;
      if (age == W + 1) begin
        m_done = 1; m_sum = pend[W-1:0]; m_cout = pend[W]; m_id = pend_id;
      end else if (age == W + 2) begin
        m_done = 0; m_gnt = 2'b00; m_busy = 0; age = 0;
      end
    end
  end

  // scoreboard helper
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {gnt, busy, done, done_id, cout, sum},
            {m_gnt, m_busy, m_done, m_id, m_cout, m_sum});
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until done is seen; returns the number of ticks taken.
  task automatic wait_done(input int budget, output int ticks);
    ticks = 0;
    while (!done && ticks < budget) begin
      tick();
      ticks = ticks + 1;
    end
    if (!done) begin
      $display("FAIL wait_done: no done within %0d cycles", budget);
      n_chk = n_chk + 1;
    end
  endtask

  int t;
  int done_cyc[$];
  logic [W-1:0] done_sum[$];
  logic done_ids[$];

  initial begin
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 1'b1;
      req_a = 1'($urandom_range(0, 1)); req_b = 1'($urandom_range(0, 1));
      a_op0 = W'($urandom); a_op1 = W'($urandom);
      b_op0 = W'($urandom); b_op1 = W'($urandom);
    end
    tick();
    chk_en = 1'b1;
    check("reset_outputs", {gnt, busy, done, done_id, cout, sum}, 32'h0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));

    // first request after reset with both high goes to A
    rst = 1'b0; req_a = 1; req_b = 1;
    a_op0 = 8'h11; a_op1 = 8'h22; b_op0 = 8'h01; b_op1 = 8'h02;
    tick();
    check("first_gnt_a", 32'(gnt), 32'h1);
    req_a = 0; req_b = 0;
    wait_done(20, t);
    check("first_sum", 32'(sum), 32'h33);
    check("first_id", 32'(done_id), 32'h0);
    tick();

    // A only: 0x3C + 0x0F
    req_a = 1; a_op0 = 8'h3C; a_op1 = 8'h0F;
    tick();
    check("a_gnt", 32'(gnt), 32'h1);
    check("a_busy", 32'(busy), 32'h1);
    req_a = 0;
    wait_done(20, t);
    check("a_done_cycle", 32'(t + 1), 32'd9);
    check("a_result", {done_id, cout, sum}, {22'h0, 1'b0, 1'b0, 8'h4B});
    tick();

    // B only: 0xFF + 0x01 wraps with carry, held after done
    req_b = 1; b_op0 = 8'hFF; b_op1 = 8'h01;
    tick();
    check("b_gnt", 32'(gnt), 32'h2);
    req_b = 0;
    wait_done(20, t);
    check("b_done_cycle", 32'(t + 1), 32'd9);
    check("b_result", {done_id, cout, sum}, {22'h0, 1'b1, 1'b1, 8'h00});
    tick();
    check("b_hold", {done, done_id, cout, sum}, {22'h0, 1'b0, 1'b1, 1'b1, 8'h00});
    check("b_idle", {gnt, busy}, 32'h0);

    // both held: alternate A, B, A every 10 cycles
    req_a = 1; req_b = 1;
    a_op0 = 8'h12; a_op1 = 8'h34; b_op0 = 8'hA0; b_op1 = 8'h70;
    for (int c = 1; c <= 29; c++) begin
      tick();
      if (done) begin
        done_cyc.push_back(c); done_sum.push_back(sum); done_ids.push_back(done_id);
      end
    end
    req_a = 0; req_b = 0;
    check("rr_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("rr_cycles", {8'(done_cyc[0]), 8'(done_cyc[1]), 8'(done_cyc[2])}, {8'd0, 8'd9, 8'd19, 8'd29});
      check("rr_ids", {done_ids[0], done_ids[1], done_ids[2]}, 32'b010);
      check("rr_sums", {done_sum[0], done_sum[1], done_sum[2]}, {8'h0, 8'h46, 8'h10, 8'h46});
    end
    tick(); tick();

    // reset in cycle 4 of an A operation
    req_a = 1; a_op0 = 8'h55; a_op1 = 8'h66;
    tick();
    req_a = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    check("abort_outputs", {gnt, busy, done, done_id, cout, sum}, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_done", {done, sum}, 32'h0);
    req_a = 1; a_op0 = 8'h80; a_op1 = 8'h80;
    tick();
    req_a = 0;
    wait_done(20, t);
    check("post_abort", {done_id, cout, sum}, {22'h0, 1'b0, 1'b1, 8'h00});
    tick();

    // operand change during RUN is ignored
    req_a = 1; a_op0 = 8'h3C; a_op1 = 8'h0F;
    tick();
    req_a = 0;
    tick(); tick();
    a_op0 = 8'h00;
    wait_done(20, t);
    check("op_change", {cout, sum}, {23'h0, 1'b0, 8'h4B});
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
